// File: rtl/cordic_pkg.sv
// cordic_pkg: shared state/quadrant types plus elaboration-time gain and arctangent tables
package cordic_pkg;
  typedef enum logic [1:0] {IDLE, ITER, OUT} state_t;
  typedef enum logic [1:0] {Q_I, Q_II, Q_III, Q_IV} quad_t;
  localparam int MAX_W = 24;
  localparam real CORDIC_K = 0.6072529350;
  localparam real PI = 3.14159265358979323846;
  typedef logic [MAX_W-1:0][MAX_W:0] atan_lut_t;
  function automatic int cordic_gain(input int w, input int g);
    return $rtoi(CORDIC_K * (2.0 ** (w - 2 + g)) + 0.5);
  endfunction
  function automatic atan_lut_t atan_lut(input int w, input int n);
    atan_lut_t lut;
    lut = '0;
    for (int k = 0; k < n; k++)
      lut[k] = (MAX_W + 1)'($rtoi($atan(2.0 ** (-k)) * (2.0 ** w) / (2.0 * PI) + 0.5));
    return lut;
  endfunction
endpackage

// File: rtl/cordic_microrot.sv
// cordic_microrot: one combinational CORDIC micro-rotation, direction taken from the residual sign
module cordic_microrot #(
  parameter int W = 16,
  parameter int G = 3,
  parameter int IW = 4
) (
  input logic signed [W+1+G:0] x,
  input logic signed [W+1+G:0] y,
  input logic signed [W:0] z,
  input logic [IW-1:0] i,
  input logic [W:0] at,
  output logic signed [W+1+G:0] x_n,
  output logic signed [W+1+G:0] y_n,
  output logic signed [W:0] z_n
);
  logic signed [W+1+G:0] xs, ys;
  logic pos;
  always_comb begin
    pos = !z[W];
    xs = x >>> i;
    ys = y >>> i;
    x_n = pos ? x - ys : x + ys;
    y_n = pos ? y + xs : y - xs;
    z_n = pos ? z - $signed(at) : z + $signed(at);
  end
endmodule

// File: rtl/cordic_sincos.sv
// cordic_sincos: iterative CORDIC sine/cosine of a full-circle binary angle with Busy/Done handshake
module cordic_sincos
  import cordic_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 16,
  parameter int G = 3
) (
  input logic Clk_i,
  input logic Rst_i,
  input logic [W-1:0] Angle_i,
  input logic Start_i,
  output logic signed [W-1:0] Sine_o,
  output logic signed [W-1:0] Cos_o,
  output logic Busy_o,
  output logic Done_o
);
  localparam int XW = W + 2 + G;
  localparam int IW = $clog2(N);
  localparam int LW = $clog2(MAX_W);
  localparam logic signed [XW-1:0] X0 = XW'(cordic_gain(W, G));
  localparam logic signed [XW-1:0] RND = XW'(G > 0 ? 1 << (G - 1) : 0);
  localparam logic signed [W+1:0] ONE = (W + 2)'(1 << (W - 2));
  localparam atan_lut_t ATAN = atan_lut(W, N);
  state_t state, nxt;
  quad_t q;
  logic [IW-1:0] i;
  logic signed [XW-1:0] x, y, x_n, y_n;
  logic signed [W:0] z, z_n;
  logic [W:0] at;
  logic signed [W-1:0] s, c;
  // drop guard bits with round-half-up, then clamp to +/-1.0
  function automatic logic signed [W-1:0] fix(input logic signed [XW-1:0] v);
    logic signed [W+1:0] t;
    t = (W + 2)'((v + RND) >>> G);
    t = t > ONE ? ONE : t < -ONE ? -ONE : t;
    return t[W-1:0];
  endfunction
  assign at = ATAN[LW'(i)][W:0];
  cordic_microrot #(.W(W), .G(G), .IW(IW)) u_rot (
    .x(x), .y(y), .z(z), .i(i), .at(at), .x_n(x_n), .y_n(y_n), .z_n(z_n)
  );
  always_comb begin
    s = fix(y);
    c = fix(x);
  end
  always_comb begin
    nxt = state;
    if (state == IDLE && Start_i) nxt = ITER;
    if (state == ITER && i == IW'(N - 1)) nxt = OUT;
    if (state == OUT) nxt = IDLE;
  end
  always_ff @(posedge Clk_i)
    state <= Rst_i ? IDLE : nxt;
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      q <= Q_I;
      i <= '0;
      x <= '0;
      y <= '0;
      z <= '0;
      Sine_o <= '0;
      Cos_o <= '0;
      Busy_o <= 1'b0;
      Done_o <= 1'b0;
    end else begin
      Done_o <= state == OUT;
      if (state == IDLE && Start_i) begin
        q <= quad_t'(Angle_i[W-1:W-2]);
        // fourth quadrant keeps the raw angle, read as a negative residual
        z <= Angle_i[W-1:W-2] == Q_IV ? {1'b1, Angle_i} : {3'b000, Angle_i[W-3:0]};
        x <= X0;
        y <= '0;
        i <= '0;
        Busy_o <= 1'b1;
      end
      if (state == ITER) begin
        x <= x_n;
        y <= y_n;
        z <= z_n;
        i <= i + 1'b1;
      end
      if (state == OUT) begin
        Sine_o <= q == Q_II ? c : q == Q_III ? -s : s;
        Cos_o <= q == Q_II ? -s : q == Q_III ? -c : c;
        Busy_o <= 1'b0;
      end
    end
  end
endmodule
